// File: rtl/avalon_mm_mult_responder_if.sv
// Avalon-MM word bus between a master wrapper and the mult responder.
interface avalon_mm_mult_responder_if;
  logic [3:0]  addr;
  logic        read;
  logic        write;
  logic [15:0] write_data;
  logic        waitrequest;
  logic [15:0] read_data;
  logic        readdatavalid;

  modport master (
    output addr, read, write, write_data,
    input  waitrequest, read_data, readdatavalid
  );

  modport slave (
    input  addr, read, write, write_data,
    output waitrequest, read_data, readdatavalid
  );
endinterface

// File: rtl/avalon_mm_mult_responder.sv
// Avalon-MM front end for the mult core: operand/result/CTRL/STATUS registers,
// combinational waitrequest stall while busy, 1-cycle pipelined reads.
module avalon_mm_mult_responder #(
  parameter int SZ = 32
) (
  input  logic                     clk,
  input  logic                     _rst,
  avalon_mm_mult_responder_if.slave avs,
  output logic [SZ-1:0]            mult_a,
  output logic [SZ-1:0]            mult_b,
  output logic                     mult_start,
  input  logic [2*SZ-1:0]          mult_res,
  input  logic                     mult_ready
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t          state_q;
  logic            first_wait_q;
  logic [SZ-1:0]   a_q;
  logic [SZ-1:0]   b_q;
  logic [2*SZ-1:0] res_q;
  logic            done_q;
  logic            err_q;
  logic            start_q;
  logic [15:0]     rdata_q;
  logic [15:0]     rdata_d;
  logic            rdv_q;

  logic busy;
  logic accepted;
  logic rd_acc;
  logic wr_acc;
  logic both_acc;
  logic ctrl_wr;

  assign busy     = (state_q != S_IDLE);
  assign avs.waitrequest = busy & (avs.read | avs.write) & (avs.addr <= 4'd8);
  assign accepted = (avs.read | avs.write) & ~avs.waitrequest;
  // Simultaneous read+write behaves as a read; the write half is discarded.
  assign rd_acc   = accepted & avs.read;
  assign wr_acc   = accepted & avs.write & ~avs.read;
  assign both_acc = accepted & avs.read & avs.write;
  assign ctrl_wr  = wr_acc & (avs.addr == 4'd8);

  always_comb begin
    rdata_d = '0;
    case (avs.addr)
      4'd0:    rdata_d = a_q[15:0];
      4'd1:    rdata_d = a_q[31:16];
      4'd2:    rdata_d = b_q[15:0];
      4'd3:    rdata_d = b_q[31:16];
      4'd4:    rdata_d = res_q[15:0];
      4'd5:    rdata_d = res_q[31:16];
      4'd6:    rdata_d = res_q[47:32];
      4'd7:    rdata_d = res_q[63:48];
      4'd9:    rdata_d = {13'd0, err_q, done_q, busy};
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q      <= S_IDLE;
      first_wait_q <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      start_q      <= 1'b0;
      rdata_q      <= '0;
      rdv_q        <= 1'b0;
    end else begin
      rdv_q   <= rd_acc;
      rdata_q <= rd_acc ? rdata_d : 16'd0;

      if (wr_acc) begin
        case (avs.addr)
          4'd0:    a_q[15:0]  <= avs.write_data;
          4'd1:    a_q[31:16] <= avs.write_data;
          4'd2:    b_q[15:0]  <= avs.write_data;
          4'd3:    b_q[31:16] <= avs.write_data;
          default: ;
        endcase
      end

      if (both_acc) begin
        err_q <= 1'b1;
      end else if (ctrl_wr && avs.write_data[1]) begin
        err_q <= 1'b0;
      end

      if (rd_acc && avs.addr == 4'd7) begin
        done_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          start_q <= 1'b0;
          if (ctrl_wr && avs.write_data[0]) begin
            state_q <= S_LAUNCH;
            start_q <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_LAUNCH: begin
          start_q      <= 1'b0;
          state_q      <= S_WAIT;
          first_wait_q <= 1'b1;
        end
        S_WAIT: begin
          // The core's ready may still reflect the previous operation here.
          first_wait_q <= 1'b0;
          if (!first_wait_q && mult_ready) begin
            res_q   <= mult_res;
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  assign avs.read_data     = rdata_q;
  assign avs.readdatavalid = rdv_q;
  assign mult_a            = a_q;
  assign mult_b            = b_q;
  assign mult_start        = start_q;

endmodule

// File: tb/tb_avalon_mm_mult_responder.sv
// Bench for avalon_mm_mult_responder: directed Avalon accesses, read scoreboard
// checked by a separate monitor, and a behavioural mult core with programmable delay.
module tb_avalon_mm_mult_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic        mult_start;
  logic [63:0] core_res;
  logic        core_rdy;

  avalon_mm_mult_responder_if bus ();

  avalon_mm_mult_responder #(.SZ(32)) dut (
    .clk        (clk),
    ._rst       (rst_n),
    .avs        (bus),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_start (mult_start),
    .mult_res   (core_res),
    .mult_ready (core_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Core model: ready stays stale for one cycle after start, then low for
  // core_delay cycles before the product appears.
  int core_delay = 3;
  int cnt;
  bit pend;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rdy <= 1'b1;
      core_res <= '0;
      cnt      <= 0;
      pend     <= 1'b0;
    end else if (mult_start) begin
      pend <= 1'b1;
    end else if (pend) begin
      pend     <= 1'b0;
      core_rdy <= 1'b0;
      cnt      <= core_delay;
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end else if (cnt == 1) begin
      cnt      <= 0;
      core_rdy <= 1'b1;
      core_res <= {32'd0, mult_a} * {32'd0, mult_b};
    end
  end

  int starts = 0;
  always @(posedge clk) if (mult_start) starts++;

  typedef struct {
    logic [15:0] exp;
    logic [15:0] mask;
    logic [3:0]  addr;
  } sb_t;
  sb_t sb[$];

  logic [15:0] last_rd = '0;
  bit          prev_rdv = 1'b0;
  int          streak = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.readdatavalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_readdatavalid", 64'd1, 64'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          if (e.mask != 16'd0)
            chk($sformatf("read_addr%0d", e.addr), {48'd0, bus.read_data & e.mask},
                {48'd0, e.exp & e.mask});
        end
        last_rd = bus.read_data;
        streak  = prev_rdv ? streak + 1 : 1;
      end else if (bus.read_data !== 16'd0) begin
        chk("read_data_zero_when_invalid", {48'd0, bus.read_data}, 64'd0);
      end
      prev_rdv = bus.readdatavalid;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic op(input bit r, input bit w, input logic [3:0] a, input logic [15:0] d,
                    output int stalls);
    stalls = 0;
    bus.read       = r;
    bus.write      = w;
    bus.addr       = a;
    bus.write_data = d;
    forever begin
      @(negedge clk);
      if (!bus.waitrequest) break;
      stalls++;
      if (stalls > 500) begin
        chk("waitrequest_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    int st;
    op(1'b0, 1'b1, a, d, st);
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] exp, input logic [15:0] mask);
    int st;
    sb.push_back('{exp: exp, mask: mask, addr: a});
    op(1'b1, 1'b0, a, 16'd0, st);
    chk("readdatavalid_latency", {63'd0, bus.readdatavalid}, 64'd1);
  endtask

  task automatic poll_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      rd(4'd9, 16'd0, 16'd0);
      @(negedge clk);
      #1;
      ok = last_rd[1];
      @(posedge clk);
      #1;
      if (ok) break;
    end
    chk("poll_done", {63'd0, ok}, 64'd1);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    int s0;
    bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.write_data = '0;
    rst_n = 1'b0;
    #23;
    chk("rst_waitrequest", {63'd0, bus.waitrequest}, 64'd0);
    chk("rst_readdatavalid", {63'd0, bus.readdatavalid}, 64'd0);
    chk("rst_read_data", {48'd0, bus.read_data}, 64'd0);
    chk("rst_mult_start", {63'd0, mult_start}, 64'd0);
    chk("rst_mult_a", {32'd0, mult_a}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rd(4'd9, 16'h0000, 16'hFFFF);
    rd(4'd4, 16'h0000, 16'hFFFF);

    // 3 * 5
    wr(4'd0, 16'd3); wr(4'd1, 16'd0); wr(4'd2, 16'd5); wr(4'd3, 16'd0);
    rd(4'd0, 16'd3, 16'hFFFF);
    rd(4'd2, 16'd5, 16'hFFFF);
    chk("mult_a_3", {32'd0, mult_a}, 64'd3);
    wr(4'd8, 16'h0001);
    rd(4'd9, 16'h0001, 16'hFFFF);
    poll_done();
    rd(4'd4, 16'h000F, 16'hFFFF);
    rd(4'd5, 16'h0000, 16'hFFFF);
    rd(4'd6, 16'h0000, 16'hFFFF);
    rd(4'd7, 16'h0000, 16'hFFFF);
    @(negedge clk); #1;
    chk("back_to_back_streak", streak, 64'd4);
    @(posedge clk); #1;
    rd(4'd9, 16'h0000, 16'hFFFF);
    rd(4'd8, 16'h0000, 16'hFFFF);
    rd(4'd12, 16'h0000, 16'hFFFF);
    wr(4'd4, 16'h1234);
    rd(4'd4, 16'h000F, 16'hFFFF);
    chk("one_start_pulse", starts, 64'd1);

    // all-ones operands
    wr(4'd0, 16'hFFFF); wr(4'd1, 16'hFFFF); wr(4'd2, 16'hFFFF); wr(4'd3, 16'hFFFF);
    chk("mult_b_ones", {32'd0, mult_b}, 64'hFFFF_FFFF);
    wr(4'd8, 16'h0001);
    poll_done();
    rd(4'd4, 16'h0001, 16'hFFFF);
    rd(4'd5, 16'h0000, 16'hFFFF);
    rd(4'd6, 16'hFFFE, 16'hFFFF);
    rd(4'd7, 16'hFFFF, 16'hFFFF);

    // read of result stalled across a slow operation
    core_delay = 10;
    wr(4'd0, 16'h1234); wr(4'd1, 16'h0000); wr(4'd2, 16'h0010); wr(4'd3, 16'h0000);
    wr(4'd8, 16'h0001);
    sb.push_back('{exp: 16'h2340, mask: 16'hFFFF, addr: 4'd4});
    op(1'b1, 1'b0, 4'd4, 16'd0, st);
    chk("stalled_read_cycles", st, 64'd13);
    chk("stalled_read_rdv", {63'd0, bus.readdatavalid}, 64'd1);
    rd(4'd5, 16'h0001, 16'hFFFF);
    rd(4'd9, 16'h0002, 16'hFFFF);
    rd(4'd7, 16'h0000, 16'hFFFF);

    // launch while busy stalls until the first operation completes
    core_delay = 3;
    wr(4'd0, 16'd2); wr(4'd1, 16'd0); wr(4'd2, 16'd7); wr(4'd3, 16'd0);
    s0 = starts;
    wr(4'd8, 16'h0001);
    op(1'b0, 1'b1, 4'd8, 16'h0001, st);
    chk("ctrl_while_busy_stalls", st, 64'd6);
    chk("second_launch_start", {63'd0, mult_start}, 64'd1);
    poll_done();
    chk("two_start_pulses", starts - s0, 64'd2);
    rd(4'd4, 16'd14, 16'hFFFF);
    rd(4'd7, 16'h0000, 16'hFFFF);

    // read+write collision
    sb.push_back('{exp: 16'd2, mask: 16'hFFFF, addr: 4'd0});
    op(1'b1, 1'b1, 4'd0, 16'hAAAA, st);
    rd(4'd0, 16'd2, 16'hFFFF);
    rd(4'd9, 16'h0004, 16'hFFFF);
    wr(4'd8, 16'h0000);
    rd(4'd9, 16'h0004, 16'hFFFF);
    wr(4'd8, 16'h0002);
    rd(4'd9, 16'h0000, 16'hFFFF);

    // reset during WAIT
    wr(4'd8, 16'h0001);
    chk("launch_start", {63'd0, mult_start}, 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.read = 1'b1; bus.addr = 4'd4;
    #1;
    chk("wait_stalls_read", {63'd0, bus.waitrequest}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_waitrequest", {63'd0, bus.waitrequest}, 64'd0);
    chk("midrst_readdatavalid", {63'd0, bus.readdatavalid}, 64'd0);
    chk("midrst_read_data", {48'd0, bus.read_data}, 64'd0);
    chk("midrst_mult_start", {63'd0, mult_start}, 64'd0);
    chk("midrst_mult_a", {32'd0, mult_a}, 64'd0);
    bus.read = 1'b0;
    s0 = starts;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rd(4'd9, 16'h0000, 16'hFFFF);
    rd(4'd4, 16'h0000, 16'hFFFF);
    rd(4'd0, 16'h0000, 16'hFFFF);
    repeat (10) @(posedge clk);
    #1;
    chk("no_start_after_reset", starts - s0, 64'd0);
    settle();
    chk("scoreboard_drained", sb.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/avalon_mm_mult_responder.md
# avalon_mm_mult_responder

Avalon-MM responder that fronts the `mult` core. It adds `waitrequest`/`readdatavalid` flow control, a control/status register and an explicit start/ready handshake to the core. It is the pipelined, stalling successor to the fixed-latency slave wrapper and sits between any Avalon-MM master wrapper and a `mult` instance held at the same hierarchy level. Result words are latched on completion and stay stable until the next operation finishes.

## Interface
- SZ, 32, operand width; only 32 is supported (two 16-bit words per operand)
- clk  input  1  clock
- _rst  input  1  reset, asynchronous, active-low
- addr  input  4  word address (map below)
- read  input  1  read request
- write  input  1  write request
- write_data  input  16  write word
- waitrequest  output  1  combinational stall; request is held by master while high
- read_data  output  16  read word, valid only with readdatavalid, else 0
- readdatavalid  output  1  one-cycle pulse per accepted read
- mult_a  output  SZ  operand A to core (driven from A register)
- mult_b  output  SZ  operand B to core (driven from B register)
- mult_start  output  1  registered one-cycle start pulse to core
- mult_res  input  2*SZ  core product
- mult_ready  input  1  core done/idle level

## Operation
- Register map:
  - 0/1: A[15:0]/A[31:16], R/W
  - 2/3: B[15:0]/B[31:16], R/W
  - 4..7: latched result words [15:0]..[63:48], RO
  - 8: CTRL, write bit0=1 launches; reads 0
  - 9: STATUS, RO; bit0 busy, bit1 done, bit2 err, other bits 0
  - 10..15: read 0, writes ignored
- FSM states:
  - IDLE: launch on accepted CTRL write with bit0=1
  - LAUNCH: mult_start=1 for exactly this cycle
  - WAIT: mult_ready is ignored in the first WAIT cycle. From the second WAIT cycle on, mult_ready=1 captures mult_res into the result register in that cycle and moves to IDLE.
- Transitions: IDLE→LAUNCH→WAIT→IDLE. busy = (state != IDLE).
- waitrequest = busy & (read|write) & (addr <= 8). Accesses to addr 9..15 never stall.
- accepted = (read|write) & !waitrequest. Only accepted accesses change state or registers.
- read and write both high: treated as read; the write is dropped and err is set.
- done:
  - set on WAIT→IDLE
  - cleared on launch or on accepted read of addr 7
- err:
  - sticky
  - cleared only by an accepted CTRL write with bit1=1 (bit0 may also be set in the same write)
- Writes to 4..7 and 9 are ignored.
- Reset values:
  - A, B, result, CTRL, STATUS = 0
  - state = IDLE
  - read_data = 0, readdatavalid = 0, mult_start = 0, waitrequest = 0
- Reset mid-operation: state returns to IDLE, mult_start drops immediately, and the captured result clears. The core is reset by the same _rst.

## Timing
- Read accepted at edge T: read_data and readdatavalid are valid in cycle T+1 (latency 1). Reads are pipelined, one per cycle, with no bubbles.
- Write accepted at edge T: register updated at T+1.
- CTRL launch accepted in cycle T:
  - LAUNCH (mult_start=1) in cycle T+1
  - WAIT from T+2
  - mult_ready first sampled at edge of cycle T+3
- mult_ready seen high in cycle U:
  - result captured at U's edge
  - IDLE, busy=0, done=1 from U+1
  - stalled requests are accepted in U+1
- A read of the result stalled during busy returns the new result.
- STATUS read during busy returns 0x0001. After completion it returns 0x0002.
- mult_a/mult_b stay constant through LAUNCH/WAIT, because operand writes stall while busy.

## Test plan
- Write A=3, B=5 (addr 0..3), CTRL=1, poll STATUS until bit1, read 4..7 -> 0x000F, 0, 0, 0; done clears after the addr 7 read.
- A=B=0xFFFFFFFF, launch, read 4..7 -> 0x0001, 0x0000, 0xFFFE, 0xFFFF.
- Read addr 4 immediately after launch, with core ready delayed 10 cycles -> waitrequest held until the cycle after mult_ready, then read_data=low product word with a single readdatavalid.
- Four back-to-back reads of 4..7 in IDLE -> readdatavalid high 4 consecutive cycles, one cycle after each read, in order.
- Write CTRL=1 while busy -> waitrequest holds the master; the second launch begins the cycle the first completes. Simultaneous read+write to addr 0 -> A unchanged, STATUS=0x0004 until CTRL=0x0002 written.
- Assert _rst during WAIT -> all outputs 0 immediately, STATUS reads 0 after release, and no readdatavalid or mult_start glitch.
